// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
//   Data-memory controller placed between a multicycle or pipelined RISC-V
//   core and an on-chip RAM. Each request is accepted with a valid/ready
//   handshake. The controller then waits a programmable number of cycles and
//   returns a single-cycle response. Writes honour byte enables. Misaligned
//   and out-of-range accesses are reported as errors. A write-only TOHOST
//   register lets a test report pass or fail.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high
//   req_valid     request present (held by the requester until accepted)
//   req_ready     controller is idle and will accept req_valid this cycle
//   req_we        1 = write, 0 = read
//   req_addr      byte address
//   req_wdata     write data
//   req_be        byte enables; bit i selects req_wdata[8i+7:8i]
//   resp_valid    one-cycle response pulse
//   resp_rdata    read data (0 on error); holds until the next response
//   resp_err      access error; holds until the next response
//   tohost_valid  one-cycle pulse in the response cycle of a TOHOST write
//   tohost_data   last value written to TOHOST
// -----------------------------------------------------------------------------
module dmem_ctrl #(
  parameter int          XLEN        = 32,
  parameter int          DEPTH       = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] TOHOST_ADDR = 32'hFFFC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [XLEN/8-1:0] req_be,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              tohost_valid,
  output logic [XLEN-1:0]   tohost_data
);

  localparam int          NB         = XLEN / 8;
  localparam int          OFF_W      = $clog2(NB);
  localparam int          IDX_W      = $clog2(DEPTH);
  localparam logic [31:0] ALIGN_MASK = 32'(NB - 1);
  localparam logic [32:0] RAM_BYTES  = 33'(DEPTH * NB);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_next;
  logic [3:0]        wait_cnt;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [NB-1:0]     be_q;
  logic [XLEN-1:0]   rdata_hold;
  logic              err_hold;

  // NOTE: the RAM array has no reset. Clearing it would need a loop over
  // every word, and the array could then no longer be mapped onto RAM macros.
  logic [XLEN-1:0]   mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Decode of the latched request. The offset is computed in 33 bits, so an
  // address below BASE_ADDR shows up as a set borrow bit.
  // ---------------------------------------------------------------------------
  logic [32:0]       offset;
  logic [IDX_W-1:0]  word_idx;
  logic              misaligned;
  logic              hit_tohost;
  logic              hit_ram;
  logic              err;
  logic [XLEN-1:0]   live_rdata;

  assign offset     = {1'b0, addr_q} - {1'b0, BASE_ADDR};
  assign word_idx   = offset[OFF_W +: IDX_W];
  assign misaligned = |(addr_q & ALIGN_MASK);
  assign hit_tohost = !misaligned && (addr_q == TOHOST_ADDR);
  assign hit_ram    = !misaligned && !hit_tohost && !offset[32] && (offset < RAM_BYTES);
  assign err        = misaligned || (hit_tohost && !we_q) || (!hit_tohost && !hit_ram);
  assign live_rdata = (!err && !we_q) ? mem[word_idx] : '0;

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  // NOTE: state_next gets its default before the case statement. Every path
  // therefore assigns it, and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (req_valid) state_next = (WAIT_STATES > 0) ? WAIT : RESP;
      WAIT: if (wait_cnt == 4'd0) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign req_ready    = (state == IDLE);
  assign resp_valid   = (state == RESP);
  // During RESP the response comes straight from the decode. Afterwards the
  // copy captured on the RESP edge keeps it visible.
  assign resp_rdata   = resp_valid ? live_rdata : rdata_hold;
  assign resp_err     = resp_valid ? err        : err_hold;
  assign tohost_valid = resp_valid && we_q && hit_tohost;

  // ---------------------------------------------------------------------------
  // State, request latch, wait counter and held response
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples values from before the edge, whatever the block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rdata_hold  <= '0;
      err_hold    <= 1'b0;
      tohost_data <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: if (req_valid) begin
          we_q     <= req_we;
          addr_q   <= req_addr;
          wdata_q  <= req_wdata;
          be_q     <= req_be;
          wait_cnt <= 4'(WAIT_STATES - 1);
        end
        WAIT: wait_cnt <= wait_cnt - 4'd1;
        RESP: begin
          rdata_hold <= live_rdata;
          err_hold   <= err;
          // The TOHOST write ignores the byte enables.
          if (we_q && hit_tohost) tohost_data <= wdata_q;
        end
        default: ;
      endcase
    end
  end

  // A write commits on the edge that ends RESP. If reset is asserted before
  // that edge, the pending write is dropped.
  always_ff @(posedge clk) begin
    if (!reset && state == RESP && we_q && hit_ram) begin
      for (int b = 0; b < NB; b++) begin
        if (be_q[b]) mem[word_idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule
